// File: rtl/fu_issue_buffer.sv
// ---------------------------------------------------------------------------
// fu_issue_buffer
//
// Routes issue requests to one of NR_FU independent per-functional-unit
// FIFOs. Each channel holds DEPTH entries and presents its oldest entry on
// its own valid/ready output port. A request that names a nonexistent
// channel is accepted, dropped, and reported on illegal_o one cycle later.
//
// Ports
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   flush_i         : synchronous clear of every channel
//   in_valid_i      : issue request present
//   in_ready_o      : request accepted this cycle
//   in_fu_i         : target channel index
//   in_op_i         : operation code
//   in_operand_a_i  : operand a
//   in_operand_b_i  : operand b
//   in_imm_i        : immediate
//   in_trans_id_i   : transaction ID
//   out_valid_o     : per-channel head-entry valid
//   out_ready_i     : per-channel pop
//   out_data_o      : per-channel head payload, channel k at [k*W +: W]
//   count_o         : per-channel occupancy, channel k at [k*CW +: CW]
//   illegal_o       : one-cycle pulse when a request to a bad channel drops
//
// Payload layout, MSB first: fu, op, operand_a, operand_b, imm, trans_id.
// ---------------------------------------------------------------------------
module fu_issue_buffer #(
    parameter int  XLEN          = 64,
    parameter int  TRANS_ID_BITS = 3,
    parameter int  FU_BITS       = 4,
    parameter int  OP_BITS       = 8,
    parameter int  NR_FU         = 4,
    parameter int  DEPTH         = 4,
    localparam int W             = FU_BITS + OP_BITS + 3 * XLEN + TRANS_ID_BITS,
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,

    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [FU_BITS-1:0]       in_fu_i,
    input  logic [OP_BITS-1:0]       in_op_i,
    input  logic [XLEN-1:0]          in_operand_a_i,
    input  logic [XLEN-1:0]          in_operand_b_i,
    input  logic [XLEN-1:0]          in_imm_i,
    input  logic [TRANS_ID_BITS-1:0] in_trans_id_i,

    output logic [NR_FU-1:0]         out_valid_o,
    input  logic [NR_FU-1:0]         out_ready_i,
    output logic [NR_FU*W-1:0]       out_data_o,
    output logic [NR_FU*CW-1:0]      count_o,
    output logic                     illegal_o
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [W-1:0]  payload_t;

    // Per-channel state
    ptr_t     rd_ptr_q [NR_FU];
    ptr_t     rd_ptr_d [NR_FU];
    ptr_t     wr_ptr_q [NR_FU];
    ptr_t     wr_ptr_d [NR_FU];
    cnt_t     count_q  [NR_FU];
    cnt_t     count_d  [NR_FU];
    payload_t mem_q    [NR_FU][DEPTH];

    logic     illegal_q;
    logic     illegal_d;

    // Request decode
    logic             fu_in_range;
    logic             in_ready;
    logic             push_any;
    logic [NR_FU-1:0] push;
    logic [NR_FU-1:0] pop;
    payload_t         in_payload;

    assign in_payload = {in_fu_i, in_op_i, in_operand_a_i, in_operand_b_i,
                         in_imm_i, in_trans_id_i};

    // -----------------------------------------------------------------------
    // Request acceptance. Readiness looks only at the registered count of the
    // target channel, so a pop in the same cycle never opens a slot for the
    // push; this keeps out_ready_i off the in_ready_o path. Out-of-range
    // targets are always ready so they can be consumed and flagged.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned and infers a latch.
        fu_in_range = (32'(in_fu_i) < NR_FU);
        in_ready    = 1'b1;
        for (int k = 0; k < NR_FU; k++) begin
            if (in_fu_i == FU_BITS'(k) && count_q[k] == CW'(DEPTH)) begin
                in_ready = 1'b0;
            end
        end
        push_any  = in_valid_i && in_ready && fu_in_range && !flush_i;
        illegal_d = in_valid_i && !fu_in_range && !flush_i;
    end

    // -----------------------------------------------------------------------
    // Per-channel pointer and occupancy update. Flush wins over any push or
    // pop in the same cycle. A pop on an empty channel is ignored.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NR_FU; k++) begin
            push[k]     = push_any && (in_fu_i == FU_BITS'(k));
            pop[k]      = (count_q[k] != '0) && out_ready_i[k] && !flush_i;
            rd_ptr_d[k] = rd_ptr_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            count_d[k]  = count_q[k];

            if (flush_i) begin
                rd_ptr_d[k] = '0;
                wr_ptr_d[k] = '0;
                count_d[k]  = '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (pop[k]) begin
                    rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
                end
                if (push[k]) begin
                    wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
                end
                unique case ({push[k], pop[k]})
                    2'b10:   count_d[k] = count_q[k] + CW'(1);
                    2'b01:   count_d[k] = count_q[k] - CW'(1);
                    default: count_d[k] = count_q[k];
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control state registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            for (int k = 0; k < NR_FU; k++) begin
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            illegal_q <= 1'b0;
        end else begin
            for (int k = 0; k < NR_FU; k++) begin
                rd_ptr_q[k] <= rd_ptr_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
            illegal_q <= illegal_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; stale contents are never visible
    // because the head output is masked by the channel count, and leaving it
    // unreset lets it map onto plain memory cells.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_FU; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= in_payload;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The head payload is forced to zero on an empty channel, which
    // also yields all-zero data while reset holds the counts at zero.
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        count_o     = '0;
        for (int k = 0; k < NR_FU; k++) begin
            out_valid_o[k]       = (count_q[k] != '0);
            out_data_o[k*W +: W] = (count_q[k] != '0) ? mem_q[k][rd_ptr_q[k]] : '0;
            count_o[k*CW +: CW]  = count_q[k];
        end
    end

    assign in_ready_o = in_ready;
    assign illegal_o  = illegal_q;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NR_FU; g++) begin : g_chk
        a_count_bound : assert property (
            @(posedge clk_i) disable iff (!rst_ni) count_q[g] <= CW'(DEPTH)
        );
        a_no_push_when_full : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            (count_q[g] == CW'(DEPTH)) |-> !push[g]
        );
    end

endmodule

// File: tb/tb_fu_issue_buffer.sv
// ---------------------------------------------------------------------------
// tb_fu_issue_buffer
//
// Drives fu_issue_buffer with directed scenarios and a randomized stream.
// A queue-per-channel reference model tracks the expected contents; each
// scenario task compares the DUT outputs against fixed values or the model.
// ---------------------------------------------------------------------------
module tb_fu_issue_buffer;

    localparam int XLEN  = 64;
    localparam int TID   = 3;
    localparam int FUB   = 4;
    localparam int OPB   = 8;
    localparam int NR_FU = 4;
    localparam int DEPTH = 4;
    localparam int W     = FUB + OPB + 3 * XLEN + TID;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                flush_i = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [FUB-1:0]      in_fu_i = '0;
    logic [OPB-1:0]      in_op_i = '0;
    logic [XLEN-1:0]     in_operand_a_i = '0;
    logic [XLEN-1:0]     in_operand_b_i = '0;
    logic [XLEN-1:0]     in_imm_i = '0;
    logic [TID-1:0]      in_trans_id_i = '0;
    logic [NR_FU-1:0]    out_valid_o;
    logic [NR_FU-1:0]    out_ready_i = '0;
    logic [NR_FU*W-1:0]  out_data_o;
    logic [NR_FU*CW-1:0] count_o;
    logic                illegal_o;

    fu_issue_buffer #(
        .XLEN          (XLEN),
        .TRANS_ID_BITS (TID),
        .FU_BITS       (FUB),
        .OP_BITS       (OPB),
        .NR_FU         (NR_FU),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_fu_i        (in_fu_i),
        .in_op_i        (in_op_i),
        .in_operand_a_i (in_operand_a_i),
        .in_operand_b_i (in_operand_b_i),
        .in_imm_i       (in_imm_i),
        .in_trans_id_i  (in_trans_id_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .count_o        (count_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue of payloads per channel, oldest at [0].
    logic [W-1:0] mq [NR_FU][$];
    logic         exp_illegal = 1'b0;

    // Present a request with random op/operands and the given fu/trans_id.
    task automatic set_req(input logic v, input int fu, input int tid);
        in_valid_i     = v;
        in_fu_i        = FUB'(fu);
        in_op_i        = OPB'($urandom());
        in_operand_a_i = {$urandom(), $urandom()};
        in_operand_b_i = {$urandom(), $urandom()};
        in_imm_i       = {$urandom(), $urandom()};
        in_trans_id_i  = TID'(tid);
    endtask

    function automatic logic model_ready();
        int fu = int'(in_fu_i);
        if (fu >= NR_FU) return 1'b1;
        return (mq[fu].size() < DEPTH);
    endfunction

    // Advance the model with the inputs as currently driven, then let the
    // DUT take the same edge and settle 1 ns past it.
    task automatic clock();
        int           fu;
        logic         rdy;
        logic         ill_next;
        logic [W-1:0] pl;
        fu       = int'(in_fu_i);
        rdy      = model_ready();
        pl       = {in_fu_i, in_op_i, in_operand_a_i, in_operand_b_i, in_imm_i, in_trans_id_i};
        ill_next = in_valid_i && (fu >= NR_FU) && !flush_i;
        if (flush_i) begin
            for (int k = 0; k < NR_FU; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < NR_FU; k++) begin
                if (out_ready_i[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            end
            if (in_valid_i && rdy && fu < NR_FU) mq[fu].push_back(pl);
        end
        @(posedge clk_i);
        #1;
        exp_illegal = ill_next;
    endtask

    task automatic idle();
        in_valid_i  = 1'b0;
        out_ready_i = '0;
        flush_i     = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        #12;
        n_tests++;
        if (out_valid_o !== '0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid_o);
        end
        n_tests++;
        if (count_o !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0h expected 0", count_o);
        end
        n_tests++;
        if (out_data_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data_o);
        end
        n_tests++;
        if (illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < NR_FU; k++) mq[k].delete();
        exp_illegal = 1'b0;
        clock();
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready_o);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_push();
        set_req(1'b1, 1, 5);
        #1;
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready_o);
        end
        clock();
        idle();
        n_tests++;
        if (out_valid_o !== 4'b0010) begin
            n_fail++; $display("FAIL single_valid: got %b expected 0010", out_valid_o);
        end
        n_tests++;
        if (out_data_o[W +: TID] !== 3'd5) begin
            n_fail++; $display("FAIL single_tid: got %0d expected 5", out_data_o[W +: TID]);
        end
        n_tests++;
        if (out_data_o[W +: W] !== mq[1][0]) begin
            n_fail++; $display("FAIL single_payload: got %0h expected %0h", out_data_o[W +: W], mq[1][0]);
        end
        n_tests++;
        if (count_o[CW +: CW] !== 3'd1) begin
            n_fail++; $display("FAIL single_count: got %0d expected 1", count_o[CW +: CW]);
        end
        out_ready_i = 4'b0010;
        clock();
        idle();
        n_tests++;
        if (out_valid_o !== '0 || out_data_o !== '0) begin
            n_fail++; $display("FAIL single_drain: valid %b data %0h expected 0/0", out_valid_o, out_data_o);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, 2, i);
            clock();
        end
        idle();
        n_tests++;
        if (count_o[2*CW +: CW] !== 3'd4) begin
            n_fail++; $display("FAIL full_count: got %0d expected 4", count_o[2*CW +: CW]);
        end
        in_fu_i = 4'd2;
        #1;
        n_tests++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_ch2: got %b expected 0", in_ready_o);
        end
        in_fu_i = 4'd0;
        #1;
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_ready_ch0: got %b expected 1", in_ready_o);
        end
        // A pop in the same cycle must not open a slot for this push.
        set_req(1'b1, 2, 7);
        out_ready_i = 4'b0100;
        #1;
        n_tests++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_with_pop: got %b expected 0", in_ready_o);
        end
        clock();
        idle();
        n_tests++;
        if (count_o[2*CW +: CW] !== 3'd3) begin
            n_fail++; $display("FAIL full_count_after_pop: got %0d expected 3", count_o[2*CW +: CW]);
        end
        n_tests++;
        if (out_data_o[2*W +: TID] !== 3'd1) begin
            n_fail++; $display("FAIL full_head_after_pop: got %0d expected 1", out_data_o[2*W +: TID]);
        end
        out_ready_i = 4'b0100;
        repeat (3) clock();
        idle();
        n_tests++;
        if (count_o !== '0) begin
            n_fail++; $display("FAIL full_drain: got %0h expected 0", count_o);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_illegal();
        set_req(1'b1, 7, 3);
        #1;
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL illegal_ready: got %b expected 1", in_ready_o);
        end
        clock();
        idle();
        n_tests++;
        if (illegal_o !== 1'b1) begin
            n_fail++; $display("FAIL illegal_pulse: got %b expected 1", illegal_o);
        end
        n_tests++;
        if (count_o !== '0 || out_valid_o !== '0) begin
            n_fail++; $display("FAIL illegal_counts: count %0h valid %b expected 0/0", count_o, out_valid_o);
        end
        clock();
        n_tests++;
        if (illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL illegal_one_cycle: got %b expected 0", illegal_o);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_push_pop_same();
        set_req(1'b1, 0, 1);
        clock();
        set_req(1'b1, 0, 2);
        clock();
        set_req(1'b1, 0, 3);
        out_ready_i = 4'b0001;
        clock();
        idle();
        n_tests++;
        if (count_o[0 +: CW] !== 3'd2) begin
            n_fail++; $display("FAIL pushpop_count: got %0d expected 2", count_o[0 +: CW]);
        end
        n_tests++;
        if (out_data_o[0 +: TID] !== 3'd2) begin
            n_fail++; $display("FAIL pushpop_head: got %0d expected 2", out_data_o[0 +: TID]);
        end
        out_ready_i = 4'b0001;
        clock();
        idle();
        n_tests++;
        if (out_data_o[0 +: W] !== mq[0][0] || out_data_o[0 +: TID] !== 3'd3) begin
            n_fail++; $display("FAIL pushpop_tail: got %0h expected %0h (tid 3)", out_data_o[0 +: W], mq[0][0]);
        end
        out_ready_i = 4'b0001;
        clock();
        idle();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 0, i);
            clock();
        end
        set_req(1'b1, 3, 6);
        clock();
        idle();
        n_tests++;
        if (count_o[0 +: CW] !== 3'd3 || count_o[3*CW +: CW] !== 3'd1) begin
            n_fail++; $display("FAIL flush_setup: got %0h expected ch0=3 ch3=1", count_o);
        end
        flush_i = 1'b1;
        set_req(1'b1, 1, 4);
        out_ready_i = 4'b1001;
        clock();
        idle();
        n_tests++;
        if (count_o !== '0) begin
            n_fail++; $display("FAIL flush_count: got %0h expected 0", count_o);
        end
        n_tests++;
        if (out_valid_o !== '0) begin
            n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid_o);
        end
        // An out-of-range request during flush must not raise illegal_o.
        flush_i = 1'b1;
        set_req(1'b1, 9, 0);
        clock();
        idle();
        n_tests++;
        if (illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_illegal: got %b expected 0", illegal_o);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random();
        logic [W-1:0] exp_d;
        logic         exp_r;
        for (int c = 0; c < 600; c++) begin
            set_req(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 7));
            flush_i = ($urandom_range(0, 40) == 0);
            for (int k = 0; k < NR_FU; k++) out_ready_i[k] = ($urandom_range(0, 2) == 0);
            #1;
            exp_r = model_ready();
            n_tests++;
            if (in_ready_o !== exp_r) begin
                n_fail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, in_ready_o, exp_r);
            end
            clock();
            n_tests++;
            if (illegal_o !== exp_illegal) begin
                n_fail++; $display("FAIL rand_illegal c%0d: got %b expected %b", c, illegal_o, exp_illegal);
            end
            for (int k = 0; k < NR_FU; k++) begin
                exp_d = (mq[k].size() > 0) ? mq[k][0] : '0;
                n_tests++;
                if (count_o[k*CW +: CW] !== CW'(mq[k].size())) begin
                    n_fail++; $display("FAIL rand_count c%0d ch%0d: got %0d expected %0d", c, k, count_o[k*CW +: CW], mq[k].size());
                end
                n_tests++;
                if (out_valid_o[k] !== (mq[k].size() > 0)) begin
                    n_fail++; $display("FAIL rand_valid c%0d ch%0d: got %b expected %b", c, k, out_valid_o[k], mq[k].size() > 0);
                end
                n_tests++;
                if (out_data_o[k*W +: W] !== exp_d) begin
                    n_fail++; $display("FAIL rand_data c%0d ch%0d: got %0h expected %0h", c, k, out_data_o[k*W +: W], exp_d);
                end
            end
        end
        idle();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        flush_i = 1'b1;
        clock();
        idle();
        set_req(1'b1, 2, 1);
        clock();
        set_req(1'b1, 2, 2);
        clock();
        idle();
        n_tests++;
        if (count_o[2*CW +: CW] !== 3'd2) begin
            n_fail++; $display("FAIL arst_setup: got %0d expected 2", count_o[2*CW +: CW]);
        end
        // Assert reset mid-cycle, well away from the next rising edge.
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (out_valid_o !== '0) begin
            n_fail++; $display("FAIL arst_valid: got %b expected 0", out_valid_o);
        end
        n_tests++;
        if (count_o !== '0 || out_data_o !== '0) begin
            n_fail++; $display("FAIL arst_state: count %0h data %0h expected 0/0", count_o, out_data_o);
        end
        for (int k = 0; k < NR_FU; k++) mq[k].delete();
        exp_illegal = 1'b0;
        #2;
        rst_ni = 1'b1;
        clock();
        n_tests++;
        if (out_valid_o !== '0 || count_o !== '0) begin
            n_fail++; $display("FAIL arst_after: valid %b count %0h expected 0/0", out_valid_o, count_o);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_illegal();
        test_push_pop_same();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
